// File: rtl/dp_result_collector.sv
// Collects datapath results behind a fixed-latency tag pipe and queues them for a
// valid/ready consumer; a credit check on issue keeps the result FIFO from overflowing.
module dp_result_collector #(
   parameter int N     = 16,
   parameter int PIPE  = 2,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     issue_valid,
   input  logic [2:0]               issue_opcode,
   output logic                     issue_ready,
   input  logic [N-1:0]             dp_Y,
   input  logic                     dp_co,
   output logic                     res_valid,
   input  logic                     res_ready,
   output logic [N-1:0]             res_Y,
   output logic                     res_co,
   output logic [2:0]               res_opcode,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     drop_err
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic          accept;
   logic          pop;
   logic          ret_valid;
   logic [2:0]    ret_tag;
   logic [CW:0]   inflight;
   logic [CW:0]   credit;
   logic [AW-1:0] wptr;
   logic [AW-1:0] rptr;

   logic [N-1:0]  mem_y   [DEPTH];
   logic          mem_co  [DEPTH];
   logic [2:0]    mem_tag [DEPTH];

   assign res_valid   = (count != '0);
   assign pop         = res_valid & res_ready;
   // Every op already in the pipe owns a future FIFO slot, so it counts against credit.
   assign credit      = {1'b0, count} + inflight - (CW+1)'(pop);
   assign issue_ready = (credit < (CW+1)'(DEPTH));
   assign accept      = issue_valid & issue_ready;

   generate
      if (PIPE == 0) begin : g_direct
         assign ret_valid = accept;
         assign ret_tag   = issue_opcode;
         assign inflight  = '0;
      end else begin : g_pipe
         logic [PIPE-1:0] stage_v;
         logic [2:0]      stage_tag [PIPE];

         always_ff @(posedge clk) begin
            if (rst) begin
               stage_v <= '0;
               for (int i = 0; i < PIPE; i++) stage_tag[i] <= '0;
            end else begin
               stage_v[0]   <= accept;
               stage_tag[0] <= issue_opcode;
               for (int i = 1; i < PIPE; i++) begin
                  stage_v[i]   <= stage_v[i-1];
                  stage_tag[i] <= stage_tag[i-1];
               end
            end
         end

         always_comb begin
            inflight = '0;
            for (int i = 0; i < PIPE; i++) inflight = inflight + (CW+1)'(stage_v[i]);
         end

         assign ret_valid = stage_v[PIPE-1];
         assign ret_tag   = stage_tag[PIPE-1];
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (!rst && ret_valid) begin
         mem_y[wptr]   <= dp_Y;
         mem_co[wptr]  <= dp_co;
         mem_tag[wptr] <= ret_tag;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr     <= '0;
         rptr     <= '0;
         count    <= '0;
         drop_err <= 1'b0;
      end else begin
         if (ret_valid) wptr <= wptr + AW'(1);
         if (pop)       rptr <= rptr + AW'(1);
         case ({ret_valid, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
         if (issue_valid && !issue_ready) drop_err <= 1'b1;
      end
   end

   // Head reads as zero while empty so stale entries never leak out after a reset.
   assign res_Y      = res_valid ? mem_y[rptr]   : '0;
   assign res_co     = res_valid ? mem_co[rptr]  : 1'b0;
   assign res_opcode = res_valid ? mem_tag[rptr] : 3'b000;

endmodule

// File: tb/tb_dp_result_collector.sv
// Bench for dp_result_collector: a PIPE=2 and a PIPE=0 instance share stimulus; a
// timestamped queue model predicts ready/valid/count/data and a negedge monitor compares.
module tb_dp_result_collector;
   localparam int N     = 16;
   localparam int DEPTH = 4;

   typedef struct {
      logic [N-1:0] y;
      logic         co;
      logic [2:0]   op;
      int           vis;
   } ent_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst = 1'b1;
   logic         iv  = 1'b0;
   logic         rr  = 1'b0;
   logic [2:0]   opc = '0;
   logic [N-1:0] a   = '0;
   logic [N-1:0] b   = '0;

   logic         iready [2];
   logic         rvalid [2];
   logic         rco    [2];
   logic         derr   [2];
   logic         dpco   [2];
   logic [N-1:0] ry     [2];
   logic [N-1:0] dpy    [2];
   logic [2:0]   rop    [2];
   logic [2:0]   rcnt   [2];

   for (genvar g = 0; g < 2; g++) begin : g_dut
      dp_result_collector #(.N(N), .PIPE(g == 0 ? 2 : 0), .DEPTH(DEPTH)) u_dut (
         .clk(clk), .rst(rst),
         .issue_valid(iv), .issue_opcode(opc), .issue_ready(iready[g]),
         .dp_Y(dpy[g]), .dp_co(dpco[g]),
         .res_valid(rvalid[g]), .res_ready(rr),
         .res_Y(ry[g]), .res_co(rco[g]), .res_opcode(rop[g]),
         .count(rcnt[g]), .drop_err(derr[g]));
   end

   ent_t q [2][$];
   bit   drop_m [2];
   int   cyc   = 0;
   int   n_cmp = 0;
   int   n_bad = 0;

   function automatic int pipe_of(input int i);
      return (i == 0) ? 2 : 0;
   endfunction

   // Reference datapath: returns {co, Y}.
   function automatic logic [N:0] dp_model(input logic [N-1:0] x, input logic [N-1:0] y,
                                           input logic [2:0] op);
      case (op)
         3'd0:    return {1'b0, x} + {1'b0, y};
         3'd1:    return {1'b0, x} - {1'b0, y};
         3'd2:    return {1'b0, x & y};
         3'd3:    return {1'b0, x | y};
         3'd4:    return {1'b0, x ^ y};
         3'd5:    return {x, 1'b0};
         3'd6:    return {1'b0, x[N-1], x[N-1:1]};
         default: return {1'b0, y};
      endcase
   endfunction

   task automatic check(input string name, input int inst, input logic [31:0] act,
                        input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s u%0d cyc=%0d got=%0h expected=%0h", name, inst, cyc, act, exp);
      end
   endtask

   // Monitor: compares the current cycle, then advances the model across the coming edge.
   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         int         nvis;
         bit         ev, pp, er;
         logic [N:0] r;
         ent_t       e;
         if (rst) begin
            q[i].delete();
            drop_m[i] = 1'b0;
         end else begin
            nvis = 0;
            for (int k = 0; k < q[i].size(); k++) if (q[i][k].vis <= cyc) nvis++;
            ev = (nvis > 0);
            pp = ev && rr;
            er = ((q[i].size() - int'(pp)) < DEPTH);
            check("issue_ready", i, 32'(iready[i]), 32'(er));
            check("res_valid",   i, 32'(rvalid[i]), 32'(ev));
            check("count",       i, 32'(rcnt[i]),   32'(nvis));
            check("drop_err",    i, 32'(derr[i]),   32'(drop_m[i]));
            if (ev) begin
               check("res_Y",      i, 32'(ry[i]),  32'(q[i][0].y));
               check("res_co",     i, 32'(rco[i]), 32'(q[i][0].co));
               check("res_opcode", i, 32'(rop[i]), 32'(q[i][0].op));
            end else begin
               check("res_Y_empty", i, 32'(ry[i]), 32'd0);
            end
            if (iv && !er) drop_m[i] = 1'b1;
            if (pp) void'(q[i].pop_front());
            if (iv && er) begin
               r     = dp_model(a, b, opc);
               e.y   = r[N-1:0];
               e.co  = r[N];
               e.op  = opc;
               e.vis = cyc + pipe_of(i) + 1;
               q[i].push_back(e);
            end
         end
      end
      cyc++;
   end

   // The datapath model: PIPE=0 answers combinationally, PIPE=2 replays the op due now.
   task automatic drive_dp();
      for (int i = 0; i < 2; i++) begin
         logic [N:0] r;
         if (pipe_of(i) == 0) begin
            r = dp_model(a, b, opc);
         end else begin
            r = (N+1)'($urandom);
            for (int k = 0; k < q[i].size(); k++)
               if (q[i][k].vis == cyc + 1) r = {q[i][k].co, q[i][k].y};
         end
         dpy[i]  = r[N-1:0];
         dpco[i] = r[N];
      end
   endtask

   task automatic cycle(input bit want, input bit polite, input bit rdy,
                        input logic [2:0] op, input logic [N-1:0] x, input logic [N-1:0] y);
      rr  = rdy;
      opc = op;
      a   = x;
      b   = y;
      iv  = 1'b0;
      #1;
      iv = want && (!polite || (iready[0] && iready[1]));
      drive_dp();
      @(posedge clk);
      #1;
   endtask

   task automatic rnd_cycle(input bit want, input bit polite, input bit rdy);
      cycle(want, polite, rdy, 3'($urandom), N'($urandom), N'($urandom));
   endtask

   initial begin
      drive_dp();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      // Single op latency: opcode 0, 3+4 = 7.
      cycle(1, 1, 0, 3'd0, N'(3), N'(4));
      repeat (4) cycle(0, 1, 0, 3'd0, '0, '0);
      repeat (2) cycle(0, 1, 1, 3'd0, '0, '0);

      // Backpressure: polite issue every cycle with the consumer stalled.
      repeat (8) rnd_cycle(1, 1, 0);
      repeat (6) rnd_cycle(0, 1, 1);

      // Fill with known values, then pop and issue together at full.
      cycle(1, 1, 0, 3'd0, N'(-5), '0);
      cycle(1, 1, 0, 3'd0, N'(12), '0);
      cycle(1, 1, 0, 3'd0, N'(0), '0);
      cycle(1, 1, 0, 3'd0, N'(32767), '0);
      repeat (2) cycle(0, 1, 0, 3'd0, '0, '0);
      cycle(1, 1, 1, 3'd1, N'(100), N'(200));
      repeat (2) rnd_cycle(1, 1, 0);
      repeat (8) rnd_cycle(0, 1, 1);

      // Forced issue against a full collector.
      repeat (6) rnd_cycle(1, 1, 0);
      repeat (3) rnd_cycle(1, 0, 0);
      repeat (2) rnd_cycle(0, 1, 0);

      // Reset in the middle of traffic.
      repeat (3) rnd_cycle(1, 1, 1'($urandom));
      rst = 1'b1;
      repeat (2) rnd_cycle(0, 1, 1'($urandom));
      rst = 1'b0;

      // Ten random ops with a toggling consumer, wrapping the pointers.
      for (int n = 0; n < 10; n++) rnd_cycle(1, 1, 1'(n % 2));
      repeat (8) rnd_cycle(0, 1, 1);

      repeat (300) rnd_cycle(($urandom % 4) != 0, 1, 1'($urandom));
      repeat (20) rnd_cycle(1'($urandom), 0, 1'($urandom));
      repeat (10) rnd_cycle(0, 1, 1);

      @(negedge clk);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
